sisc_ctrl_seq: RTL

Multi-cycle control sequencer and instruction decoder for the SISC core. It is the consuming end of the instruction word `ir` that the stimulus side presents, one instruction every 5 clock cycles. It captures `ir` once per instruction, steps FETCH→DECODE→EXECUTE→MEM→WRITEBACK, and drives the datapath strobes: register-file write, ALU operation/source select, status-register enable and PC increment. HALT freezes the core until reset.

---
 rtl/sisc_pkg.sv | 42 ++++
 rtl/sisc_ir_decode.sv | 29 ++
 rtl/sisc_ctrl_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC control sequencer: opcodes, state
// encodings, ALU function codes and instruction field positions.
package sisc_pkg;

  // Opcodes (ir[31:28])
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ALU = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Sequencer states; encoding 6 is unused and recovers to START
  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd7
  } state_t;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_NOT = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_AND = 4'h6;
  localparam logic [3:0] ALU_XOR = 4'h7;
  localparam logic [3:0] ALU_ROR = 4'h8;
  localparam logic [3:0] ALU_ROL = 4'h9;
  localparam logic [3:0] ALU_SHR = 4'hA;
  localparam logic [3:0] ALU_SHL = 4'hB;

  // Field LSB positions within the instruction word
  localparam int OP_LSB  = 28;
  localparam int MM_LSB  = 24;
  localparam int RS_LSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/sisc_ir_decode.sv
// Combinational opcode classifier. Turns the captured op/mm/fn fields into
// the class flags the sequencer needs plus the ALU function to drive.
module sisc_ir_decode
  import sisc_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] mm,
  input  logic [3:0] fn,
  output logic       is_alu,
  output logic       is_imm,
  output logic       is_halt,
  output logic       is_illegal,
  output logic [3:0] alu_fn
);

  // Only mm[3] selects behaviour; the remaining mode bits are reserved
  logic unused_mm;
  assign unused_mm = ^mm[2:0];

  // Classify the opcode; anything not NOP/ALU/HALT is undefined
  always_comb begin
    is_alu     = (op == OP_ALU);
    is_imm     = (op == OP_ALU) && mm[3];
    is_halt    = (op == OP_HLT);
    is_illegal = !((op == OP_NOP) || (op == OP_ALU) || (op == OP_HLT));
    alu_fn     = is_imm ? ALU_ADD : fn;
  end

endmodule

// File: rtl/sisc_ctrl_seq.sv
// SISC multi-cycle control sequencer. Captures one instruction per 5-cycle
// FETCH..WRITEBACK pass and drives the datapath strobes as Moore outputs
// of the current state and the captured instruction. HALT is absorbing.
module sisc_ctrl_seq
  import sisc_pkg::*;
#(
  parameter int IR_W         = 32,
  parameter int OP_HI        = 31,
  parameter int START_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [IR_W-1:0] ir,
  output logic            ir_load,
  output logic            pc_inc,
  output logic            rf_we,
  output logic            rd_sel,
  output logic            alu_src,
  output logic [3:0]      alu_op,
  output logic            stat_en,
  output logic            halted,
  output logic            illegal,
  output logic [2:0]      state
);

  state_t          cur_state;
  state_t          nxt_state;
  logic [IR_W-1:0] ir_q;
  logic            illegal_q;
  logic [1:0]      start_cnt;
  logic            start_done;

  logic [3:0] op;
  logic [3:0] mm;
  logic [3:0] fn;
  logic       is_alu;
  logic       is_imm;
  logic       is_halt;
  logic       is_illegal;
  logic [3:0] alu_fn;

  // Register fields rs/rt/rd/imm feed the datapath directly, not the sequencer
  logic unused_ir;
  assign unused_ir = ^ir_q;

  assign op         = ir_q[OP_HI -: 4];
  assign mm         = ir_q[OP_HI-4 -: 4];
  assign fn         = ir_q[FN_LSB +: 4];
  assign start_done = (start_cnt == 2'(START_CYCLES - 1));
  assign state      = cur_state;

  sisc_ir_decode u_decode (
    .op         (op),
    .mm         (mm),
    .fn         (fn),
    .is_alu     (is_alu),
    .is_imm     (is_imm),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_fn     (alu_fn)
  );

  // State, instruction capture, sticky illegal flag and start-delay counter
  always_ff @(posedge clk) begin
    if (rst_f) begin
      cur_state <= ST_START;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      start_cnt <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == ST_FETCH) ir_q <= ir;
      if ((cur_state == ST_DECODE) && is_illegal) illegal_q <= 1'b1;
      if ((cur_state == ST_START) && !start_done) start_cnt <= start_cnt + 2'd1;
    end
  end

  // Next-state and Moore strobe decode
  always_comb begin
    nxt_state = cur_state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    rf_we     = 1'b0;
    rd_sel    = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 4'h0;
    stat_en   = 1'b0;
    halted    = 1'b0;
    // Flag shows in DECODE itself, then the registered copy holds it
    illegal   = illegal_q | ((cur_state == ST_DECODE) && is_illegal);
    case (cur_state)
      ST_START: begin
        if (start_done) nxt_state = ST_FETCH;
      end
      ST_FETCH: begin
        ir_load   = 1'b1;
        nxt_state = ST_DECODE;
      end
      ST_DECODE: begin
        nxt_state = is_halt ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_alu) begin
          alu_src = is_imm;
          alu_op  = alu_fn;
          stat_en = 1'b1;
        end
        nxt_state = ST_MEM;
      end
      ST_MEM: begin
        nxt_state = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_inc = 1'b1;
        if (is_alu) begin
          rf_we   = 1'b1;
          rd_sel  = is_imm;
          alu_src = is_imm;
          alu_op  = alu_fn;
        end
        nxt_state = ST_FETCH;
      end
      ST_HALT: begin
        halted    = 1'b1;
        nxt_state = ST_HALT;
      end
      default: begin
        nxt_state = ST_START;
      end
    endcase
  end

endmodule
